sparse_dot_engine: RTL and testbench

Parametrised successor to the single-weight inference pipeline. It streams LANES activations per beat against rows of packed INT4 weights held in an internal memory. Each lane dequantises, zero-detects and multiplies; the lane products are summed and the sum is accumulated with saturation. One dot-product result is returned per job through a valid/ready handshake. It sits between the weight loader and the layer sequencer.

---
 rtl/sparse_dot_engine.sv | 246 ++++++++++++++++++++++++
 tb/tb_sparse_dot_engine.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_dot_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sparse_dot_engine                                            |
// | Description : Streams LANES INT8 activations per beat against rows of      |
// |               packed INT4 weights, dequantises, skips zero lanes,          |
// |               multiplies, sums and accumulates with saturation. Returns    |
// |               one dot product per job through a valid/ready handshake.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sparse_dot_engine #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              dq_scale,
    input  logic [3:0]              dq_offset,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [LANES*4-1:0]      wr_data,
    output logic                    wr_err,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W:0]         num_rows,
    output logic                    busy,
    input  logic                    act_valid,
    output logic                    act_ready,
    input  logic [LANES*8-1:0]      act_data,
    output logic                    result_valid,
    input  logic                    result_ready,
    output logic signed [ACC_W-1:0] result,
    output logic [15:0]             skip_count,
    output logic                    sat_flag
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam int c_DEPTH  = 2 ** ADDR_W;
    localparam int c_SKIP_W = $clog2(LANES + 1);
    // Sum of LANES signed 16-bit products, plus one guard bit
    localparam int c_SUM_W  = 17 + $clog2(LANES);
    // Wide enough that accumulator + beat sum can never wrap before clamping
    localparam int c_WIDE_W = ((ACC_W > c_SUM_W) ? ACC_W : c_SUM_W) + 1;

    localparam logic signed [c_WIDE_W-1:0] c_ACC_MAX =
        c_WIDE_W'({1'b0, {(ACC_W-1){1'b1}}});
    localparam logic signed [c_WIDE_W-1:0] c_ACC_MIN =
        c_WIDE_W'($signed({1'b1, {(ACC_W-1){1'b0}}}));

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       w_xfer;
    logic                       w_start;

    logic [LANES*4-1:0]         r_mem [c_DEPTH];
    logic [ADDR_W-1:0]          r_ptr;
    logic [ADDR_W:0]            r_remaining;
    logic [3:0]                 r_scale;
    logic [3:0]                 r_offset;
    logic                       r_wr_err;

    logic                       r_s1_valid;
    logic [LANES*4-1:0]         r_s1_w;
    logic [LANES*8-1:0]         r_s1_act;

    logic [LANES*16-1:0]        w_prod;
    logic [LANES-1:0]           w_zero;
    logic [c_SKIP_W-1:0]        w_skip_beat;

    logic                       r_s2_valid;
    logic [LANES*16-1:0]        r_s2_prod;
    logic [c_SKIP_W-1:0]        r_s2_skip;

    logic signed [c_SUM_W-1:0]  w_sum;
    logic signed [c_WIDE_W-1:0] w_acc_wide;
    logic signed [ACC_W-1:0]    w_acc_next;
    logic                       w_acc_sat;

    logic signed [ACC_W-1:0]    r_acc;
    logic [15:0]                r_skip;
    logic                       r_sat;

    assign w_start = start && (r_state == c_IDLE);
    assign w_xfer  = act_valid && (r_state == c_RUN);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_state_nxt  = r_state;
        act_ready    = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (r_state)
            c_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = (num_rows == '0) ? c_DONE : c_RUN;
                end
            end
            c_RUN: begin
                act_ready = 1'b1;
                if (w_xfer && (r_remaining == (ADDR_W+1)'(1))) begin
                    w_state_nxt = c_DRAIN;
                end
            end
            c_DRAIN: begin
                if (!r_s1_valid && !r_s2_valid) begin
                    w_state_nxt = c_DONE;
                end
            end
            default: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
        endcase
    end

    // Weight memory: written only while idle, contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en && (r_state == c_IDLE)) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Per-lane dequantise, zero detect and multiply (stage 2 combinational)
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0]         w_q;
        logic signed [7:0]  w_act;
        logic signed [4:0]  w_w;
        logic signed [9:0]  w_d_full;
        logic signed [7:0]  w_d;
        logic signed [15:0] w_mul;

        assign w_q      = r_s1_w[4*l +: 4];
        assign w_act    = r_s1_act[8*l +: 8];
        assign w_w      = $signed({1'b0, w_q}) - $signed({1'b0, r_offset});
        assign w_d_full = w_w * $signed({6'b0, r_scale});
        assign w_d      = (w_d_full > 10'sd127)  ? 8'h7F :
                          (w_d_full < -10'sd128) ? 8'h80 : w_d_full[7:0];
        assign w_zero[l] = (w_d == 8'sd0) || (w_act == 8'sd0);
        assign w_mul    = w_d * w_act;
        assign w_prod[16*l +: 16] = w_zero[l] ? 16'h0000 : w_mul;
    end

    // Number of lanes skipped in the beat currently in stage 2
    always_comb begin
        w_skip_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            w_skip_beat = w_skip_beat + c_SKIP_W'(w_zero[i]);
        end
    end

    // Stage 3 lane sum and saturating accumulate
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + c_SUM_W'($signed(r_s2_prod[16*i +: 16]));
        end
        w_acc_wide = c_WIDE_W'(r_acc) + c_WIDE_W'(w_sum);
        w_acc_sat  = 1'b0;
        w_acc_next = w_acc_wide[ACC_W-1:0];
        if (w_acc_wide > c_ACC_MAX) begin
            w_acc_sat  = 1'b1;
            w_acc_next = c_ACC_MAX[ACC_W-1:0];
        end else if (w_acc_wide < c_ACC_MIN) begin
            w_acc_sat  = 1'b1;
            w_acc_next = c_ACC_MIN[ACC_W-1:0];
        end
    end

    // Job setup, beat acceptance, pipeline stages and accumulation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_scale     <= '0;
            r_offset    <= '0;
            r_wr_err    <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_w      <= '0;
            r_s1_act    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_prod   <= '0;
            r_s2_skip   <= '0;
            r_acc       <= '0;
            r_skip      <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_wr_err <= wr_en && (r_state != c_IDLE);

            r_s1_valid <= w_xfer;
            if (w_xfer) begin
                r_s1_w      <= r_mem[r_ptr];
                r_s1_act    <= act_data;
                r_ptr       <= r_ptr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end

            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_prod <= w_prod;
                r_s2_skip <= w_skip_beat;
            end

            if (r_s2_valid) begin
                r_acc  <= w_acc_next;
                r_skip <= r_skip + 16'(r_s2_skip);
                if (w_acc_sat) begin
                    r_sat <= 1'b1;
                end
            end

            // Pipeline is always empty in IDLE, so this never races stage 3
            if (w_start) begin
                r_ptr       <= base_addr;
                r_remaining <= num_rows;
                r_scale     <= dq_scale;
                r_offset    <= dq_offset;
                r_acc       <= '0;
                r_skip      <= '0;
                r_sat       <= 1'b0;
            end
        end
    end

    assign wr_err     = r_wr_err;
    assign result     = r_acc;
    assign skip_count = r_skip;
    assign sat_flag   = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_sparse_dot_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sparse_dot_engine                                         |
// | Description : Self-checking bench for sparse_dot_engine with an           |
// |               arithmetic reference model of the dot product.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sparse_dot_engine;

    localparam int LANES  = 4;
    localparam int ADDR_W = 4;
    localparam int ACC_W  = 18;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam longint ACC_MAX = (longint'(1) << (ACC_W - 1)) - 1;
    localparam longint ACC_MIN = -ACC_MAX - 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [3:0]              dq_scale;
    logic [3:0]              dq_offset;
    logic                    wr_en;
    logic [ADDR_W-1:0]       wr_addr;
    logic [LANES*4-1:0]      wr_data;
    logic                    wr_err;
    logic                    start;
    logic [ADDR_W-1:0]       base_addr;
    logic [ADDR_W:0]         num_rows;
    logic                    busy;
    logic                    act_valid;
    logic                    act_ready;
    logic [LANES*8-1:0]      act_data;
    logic                    result_valid;
    logic                    result_ready;
    logic signed [ACC_W-1:0] result;
    logic [15:0]             skip_count;
    logic                    sat_flag;

    logic [LANES*4-1:0] mem_model [DEPTH];
    logic [LANES*8-1:0] acts [DEPTH];
    int                 checks = 0;
    int                 passes = 0;
    longint             got_result;
    logic               got_sat;

    sparse_dot_engine #(.LANES(LANES), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .dq_scale(dq_scale), .dq_offset(dq_offset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err),
        .start(start), .base_addr(base_addr), .num_rows(num_rows), .busy(busy),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .result_valid(result_valid), .result_ready(result_ready), .result(result),
        .skip_count(skip_count), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    // Safety net: every wait below is bounded, this only catches the unforeseen
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    endtask

    // Reference: dequantise, clamp, skip zeros, sum lanes, clamp accumulator per beat
    function automatic void model(input int base, input int n, input int sc, input int off,
                                  output longint acc, output int skip, output bit sat);
        acc  = 0;
        skip = 0;
        sat  = 0;
        for (int i = 0; i < n; i++) begin
            logic [LANES*4-1:0] row;
            logic [LANES*8-1:0] a;
            longint             sum;
            row = mem_model[(base + i) % DEPTH];
            a   = acts[i];
            sum = 0;
            for (int l = 0; l < LANES; l++) begin
                logic [3:0]        qn;
                logic signed [7:0] ab;
                int                d;
                int                av;
                qn = row[4*l +: 4];
                ab = a[8*l +: 8];
                av = int'(ab);
                d  = (int'(qn) - off) * sc;
                if (d > 127)  d = 127;
                if (d < -128) d = -128;
                if (d == 0 || av == 0) skip++;
                else sum += longint'(d * av);
            end
            acc += sum;
            if (acc > ACC_MAX) begin
                acc = ACC_MAX;
                sat = 1;
            end else if (acc < ACC_MIN) begin
                acc = ACC_MIN;
                sat = 1;
            end
        end
    endfunction

    task automatic write_row(input int addr, input logic [LANES*4-1:0] data);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = data;
        @(negedge clk);
        wr_en   = 1'b0;
        mem_model[addr] = data;
    endtask

    task automatic fill_acts(input int n);
        for (int i = 0; i < n; i++) begin
            for (int l = 0; l < LANES; l++) begin
                acts[i][8*l +: 8] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            end
        end
    endtask

    task automatic run_job(input string tag, input int base, input int n,
                           input logic [3:0] sc, input logic [3:0] off,
                           input bit bubbles, input bit wr_probe, input bit hold);
        longint e_acc;
        int     e_skip;
        bit     e_sat;
        int     k;
        int     cyc;
        int     lat;
        bit     xfer;
        model(base, n, int'(sc), int'(off), e_acc, e_skip, e_sat);
        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        num_rows  = (ADDR_W+1)'(n);
        dq_scale  = sc;
        dq_offset = off;
        @(negedge clk);
        // Job parameters are latched at start; scrambling them must not matter
        start     = 1'b0;
        base_addr = ADDR_W'($urandom);
        num_rows  = (ADDR_W+1)'($urandom);
        dq_scale  = 4'($urandom);
        dq_offset = 4'($urandom);
        if (wr_probe && n > 0) begin
            wr_en   = 1'b1;
            wr_addr = ADDR_W'(base);
            wr_data = ~mem_model[base % DEPTH];
            @(negedge clk);
            wr_en = 1'b0;
            chk({tag, "/wr_err_pulse"}, 64'(wr_err), 64'(1));
            @(negedge clk);
            chk({tag, "/wr_err_clear"}, 64'(wr_err), 64'(0));
        end
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 400) begin
            act_valid = bubbles ? (cyc % 2 == 0) : 1'b1;
            act_data  = acts[k];
            xfer      = act_valid && act_ready;
            @(negedge clk);
            cyc++;
            if (xfer) k++;
        end
        chk({tag, "/beats_accepted"}, 64'(k), 64'(n));
        if (n > 0) chk({tag, "/ready_low_after_last"}, 64'(act_ready), 64'(0));
        // Junk beats offered while draining must be ignored
        act_valid = 1'b1;
        act_data  = 32'($urandom);
        lat = 0;
        while (!result_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        act_valid = 1'b0;
        chk({tag, "/latency"}, 64'(lat), 64'((n == 0) ? 0 : 3));
        chk({tag, "/result"}, 64'(result), 64'(e_acc));
        chk({tag, "/skip_count"}, 64'(skip_count), 64'(e_skip));
        chk({tag, "/sat_flag"}, 64'(sat_flag), 64'(e_sat));
        got_result = longint'(result);
        got_sat    = sat_flag;
        if (hold) begin
            for (int h = 0; h < 5; h++) begin
                result_ready = 1'b0;
                start        = (h == 1);
                @(negedge clk);
                chk({tag, "/hold_valid"}, 64'(result_valid), 64'(1));
                chk({tag, "/hold_result"}, 64'(result), 64'(e_acc));
            end
            start        = 1'b1;
            result_ready = 1'b1;
            @(negedge clk);
            start        = 1'b0;
            result_ready = 1'b0;
            chk({tag, "/valid_dropped"}, 64'(result_valid), 64'(0));
            chk({tag, "/start_at_handshake_ignored"}, 64'(busy), 64'(0));
        end else begin
            result_ready = 1'b1;
            @(negedge clk);
            result_ready = 1'b0;
            chk({tag, "/valid_dropped"}, 64'(result_valid), 64'(0));
        end
    endtask

    initial begin
        rst = 1'b1; dq_scale = '0; dq_offset = '0; wr_en = 1'b0; wr_addr = '0;
        wr_data = '0; start = 1'b0; base_addr = '0; num_rows = '0;
        act_valid = 1'b0; act_data = '0; result_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/busy", 64'(busy), 64'(0));
        chk("rst/act_ready", 64'(act_ready), 64'(0));
        chk("rst/result_valid", 64'(result_valid), 64'(0));
        chk("rst/wr_err", 64'(wr_err), 64'(0));
        chk("rst/result", 64'(result), 64'(0));
        chk("rst/skip_count", 64'(skip_count), 64'(0));
        chk("rst/sat_flag", 64'(sat_flag), 64'(0));
        rst = 1'b0;

        for (int r = 0; r < DEPTH; r++) write_row(r, 16'($urandom));

        // All lanes 2, scale 3: 4 * 6 * 10
        write_row(0, 16'h2222);
        acts[0] = 32'h0A0A0A0A;
        run_job("basic", 0, 1, 4'd3, 4'd0, 0, 0, 0);
        chk("basic/value", 64'(got_result), 64'(240));

        // Three of four lanes skipped, only 1*9 survives
        write_row(1, 16'h1010);
        acts[0] = 32'h09070005;
        run_job("zero_skip", 1, 1, 4'd1, 4'd0, 0, 0, 0);
        chk("zero_skip/value", 64'(got_result), 64'(9));

        // Async reset in the middle of a job
        @(negedge clk);
        start = 1'b1; base_addr = '0; num_rows = 5'd8; dq_scale = 4'd3; dq_offset = 4'd1;
        @(negedge clk);
        start = 1'b0;
        act_valid = 1'b1; act_data = 32'h01020300;
        repeat (2) @(negedge clk);
        act_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst/busy", 64'(busy), 64'(0));
        chk("midrst/act_ready", 64'(act_ready), 64'(0));
        chk("midrst/result", 64'(result), 64'(0));
        chk("midrst/skip_count", 64'(skip_count), 64'(0));
        chk("midrst/result_valid", 64'(result_valid), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        fill_acts(3);
        run_job("after_rst", 0, 3, 4'd5, 4'd2, 0, 0, 0);

        // Wrap-around rows 14,15,0,1 with bubbles
        for (int r = 0; r < 4; r++) write_row((14 + r) % DEPTH, 16'($urandom));
        fill_acts(4);
        run_job("wrap", 14, 4, 4'($urandom_range(1, 15)), 4'($urandom), 1, 0, 0);

        // d = (0-15)*15 clamps to -128, times act -128 drives the accumulator to max
        for (int r = 2; r < 6; r++) write_row(r, 16'h0000);
        for (int i = 0; i < 4; i++) acts[i] = 32'h80808080;
        run_job("sat", 2, 4, 4'd15, 4'd15, 0, 0, 0);
        chk("sat/value", 64'(got_result), 64'(131071));
        chk("sat/flag", 64'(got_sat), 64'(1));

        // Control edges
        run_job("zero_rows", 5, 0, 4'd1, 4'd0, 0, 0, 1);
        fill_acts(3);
        run_job("wr_probe", 7, 3, 4'd2, 4'd3, 0, 1, 0);
        fill_acts(2);
        run_job("hold", 9, 2, 4'd7, 4'd4, 1, 0, 1);

        // Randomised jobs
        for (int j = 0; j < 6; j++) begin
            fill_acts(DEPTH);
            run_job($sformatf("rand%0d", j), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(1, DEPTH)), 4'($urandom), 4'($urandom),
                    bit'($urandom_range(0, 1)), 0, 0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
